ball_mover: RTL

//  Per-frame ball animation stage. Sits beside the brick-drawing datapath and feeds the

---
 rtl/ball_mover.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/ball_mover.sv
// Ball animation stage: erases, moves and redraws a square ball on the shared VGA plot bus,
// bouncing off the walls and the paddle and flagging a lost ball at the bottom edge.
module ball_mover #(
  parameter int         SCREEN_W        = 160,
  parameter int         SCREEN_H        = 120,
  parameter int         BALL_SIZE       = 2,
  parameter int         FRAMES_PER_STEP = 4,
  parameter int         START_X         = 80,
  parameter int         START_Y         = 100,
  parameter int         PADDLE_Y        = 112,
  parameter int         PADDLE_W        = 16,
  parameter logic [2:0] BALL_COLOUR     = 3'b111,
  parameter logic [2:0] BG_COLOUR       = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [7:0] paddle_x,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       ball_lost,
  output logic [7:0] ball_x,
  output logic [6:0] ball_y
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_DRAW, S_WAIT, S_ERASE, S_MOVE, S_DRAW, S_LOST
  } state_t;

  localparam logic [7:0] XMAX       = 8'(SCREEN_W - BALL_SIZE);
  localparam logic [6:0] YMAX       = 7'(SCREEN_H - BALL_SIZE);
  localparam logic [6:0] YPAD       = 7'(PADDLE_Y - BALL_SIZE);
  localparam logic [1:0] PIX_LAST   = 2'(BALL_SIZE - 1);
  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_STEP - 1);
  localparam logic [8:0] SIZE9      = 9'(BALL_SIZE);
  localparam logic [8:0] PADW9      = 9'(PADDLE_W);

  state_t     state_q;
  logic [7:0] ball_x_q, ball_x_d;
  logic [6:0] ball_y_q, ball_y_d;
  logic       dx_pos_q, dx_pos_d;
  logic       dy_pos_q, dy_pos_d;
  logic       lost_d;
  logic       overlap;
  logic [1:0] px_q, px_d;
  logic [1:0] py_q, py_d;
  logic       pix_last;
  logic [7:0] frame_cnt_q;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] colour_q;
  logic       plot_q;
  logic       busy_q;
  logic       lost_q;

  assign x         = x_q;
  assign y         = y_q;
  assign colour    = colour_q;
  assign plot      = plot_q;
  assign busy      = busy_q;
  assign ball_lost = lost_q;
  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;

  // Row-major walk over the ball footprint; counters wrap back to (0,0) after the last pixel.
  always_comb begin
    pix_last = (px_q == PIX_LAST) && (py_q == PIX_LAST);
    px_d     = px_q + 2'd1;
    py_d     = py_q;
    if (px_q == PIX_LAST) begin
      px_d = 2'd0;
      py_d = (py_q == PIX_LAST) ? 2'd0 : py_q + 2'd1;
    end
  end

  // Next position; X and Y bounce independently so a corner hit reflects both.
  always_comb begin
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_pos_d = dx_pos_q;
    dy_pos_d = dy_pos_q;
    lost_d   = 1'b0;
    overlap  = (({1'b0, ball_x_q} + SIZE9) > {1'b0, paddle_x}) &&
               ({1'b0, ball_x_q} < ({1'b0, paddle_x} + PADW9));

    if (!dx_pos_q && ball_x_q == 8'd0) begin
      dx_pos_d = 1'b1;
      ball_x_d = 8'd1;
    end else if (dx_pos_q && ball_x_q == XMAX) begin
      dx_pos_d = 1'b0;
      ball_x_d = ball_x_q - 8'd1;
    end else begin
      ball_x_d = dx_pos_q ? ball_x_q + 8'd1 : ball_x_q - 8'd1;
    end

    if (!dy_pos_q && ball_y_q == 7'd0) begin
      dy_pos_d = 1'b1;
      ball_y_d = 7'd1;
    end else if (dy_pos_q && ball_y_q == YPAD && overlap) begin
      dy_pos_d = 1'b0;
      ball_y_d = ball_y_q - 7'd1;
    end else if (dy_pos_q && ball_y_q == YMAX) begin
      lost_d = 1'b1;
    end else begin
      ball_y_d = dy_pos_q ? ball_y_q + 7'd1 : ball_y_q - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      ball_x_q    <= 8'(START_X);
      ball_y_q    <= 7'(START_Y);
      dx_pos_q    <= 1'b1;
      dy_pos_q    <= 1'b0;
      px_q        <= 2'd0;
      py_q        <= 2'd0;
      frame_cnt_q <= 8'd0;
      x_q         <= 8'd0;
      y_q         <= 7'd0;
      colour_q    <= 3'd0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      busy_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (enable) state_q <= S_INIT_DRAW;
        end
        S_INIT_DRAW, S_ERASE, S_DRAW: begin
          plot_q   <= 1'b1;
          x_q      <= ball_x_q + {6'd0, px_q};
          y_q      <= ball_y_q + {5'd0, py_q};
          colour_q <= (state_q == S_ERASE) ? BG_COLOUR : BALL_COLOUR;
          px_q     <= px_d;
          py_q     <= py_d;
          if (!pix_last) begin
            busy_q <= (state_q != S_INIT_DRAW);
          end else if (state_q == S_ERASE) begin
            state_q <= S_MOVE;
            busy_q  <= 1'b1;
          end else if (state_q == S_DRAW && !enable) begin
            state_q <= S_IDLE;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!enable) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= 8'd0;
          end else if (frame_tick) begin
            if (frame_cnt_q == FRAME_LAST) begin
              frame_cnt_q <= 8'd0;
              state_q     <= S_ERASE;
              busy_q      <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 8'd1;
            end
          end
        end
        S_MOVE: begin
          ball_x_q <= ball_x_d;
          ball_y_q <= ball_y_d;
          dx_pos_q <= dx_pos_d;
          dy_pos_q <= dy_pos_d;
          if (lost_d) begin
            state_q <= S_LOST;
            lost_q  <= 1'b1;
          end else begin
            state_q <= S_DRAW;
            busy_q  <= 1'b1;
          end
        end
        S_LOST: begin
          lost_q <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
